sort_seq_ctrl: RTL



---
 rtl/sort_seq_ctrl_pkg.sv | 23 ++
 rtl/sort_seq_ctrl_if.sv | 42 ++++
 rtl/sort_cmp_swap.sv | 20 ++
 rtl/sort_seq_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sort_seq_ctrl_pkg.sv
// Shared types for the packet sort sequencer:
// clogb2 helper, FSM state encoding, sort direction constants.
package sort_pkg;

  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DISCARD,
    SORT,
    OUTPUT
  } state_t;

  localparam bit CMP_ASC  = 1'b1;
  localparam bit CMP_DESC = 1'b0;

endpackage

// File: rtl/sort_seq_ctrl_if.sv
// Stream bundle for the sort sequencer: sink beats in, sorted words out.
// slave = sequencer view, master = producer/consumer view.
interface sort_seq_ctrl_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  snk_valid;
  logic                  snk_sop;
  logic                  snk_eop;
  logic [DATA_WIDTH-1:0] snk_data;
  logic                  snk_ready;

  logic                  src_valid;
  logic                  src_sop;
  logic                  src_eop;
  logic [DATA_WIDTH-1:0] src_data;

  modport slave (
    input  snk_valid,
    input  snk_sop,
    input  snk_eop,
    input  snk_data,
    output snk_ready,
    output src_valid,
    output src_sop,
    output src_eop,
    output src_data
  );

  modport master (
    output snk_valid,
    output snk_sop,
    output snk_eop,
    output snk_data,
    input  snk_ready,
    input  src_valid,
    input  src_sop,
    input  src_eop,
    input  src_data
  );

endinterface

// File: rtl/sort_cmp_swap.sv
// Compare-swap cell: a/b in, out_a/out_b in requested order.
// swap is high only when a and b are strictly out of order.
module sort_cmp_swap
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit ASCENDING  = CMP_ASC
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic                  swap
);

  assign swap  = (ASCENDING == CMP_ASC) ? (a > b) : (a < b);
  assign out_a = swap ? b : a;
  assign out_b = swap ? a : b;

endmodule

// File: rtl/sort_seq_ctrl.sv
// Packet sort sequencer: load one packet, bubble sort in place, stream out.
// Ports: snk_clock/snk_reset, io (stream bundle), busy, pkt_len, err_overflow.
module sort_seq_ctrl
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LENGTH = 16,
  parameter bit ASCENDING  = CMP_ASC,
  localparam int IW = clogb2(MAX_LENGTH),
  localparam int LW = IW + 1
) (
  input  logic           snk_clock,
  input  logic           snk_reset,
  sort_seq_ctrl_if.slave io,
  output logic           busy,
  output logic [LW-1:0]  pkt_len,
  output logic           err_overflow
);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t buf_q [MAX_LENGTH];

  state_t state_q, state_d;

  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] pass_q, pass_d;
  logic [LW-1:0] oidx_q, oidx_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          swp_q, swp_d;

  logic  vld_q, vld_d;
  logic  sop_q, sop_d;
  logic  eop_q, eop_d;
  word_t dat_q, dat_d;
  logic  err_q, err_d;

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic          sw_en;

  word_t cmp_a, cmp_b;
  word_t cmp_oa, cmp_ob;
  logic  cmp_sw;

  logic          accept;
  logic [LW-1:0] lim;
  logic          last_cmp;
  logic          final_pass;
  logic          sorted;

  assign io.snk_ready = !snk_reset &&
                        (state_q == IDLE ||
                         state_q == LOAD ||
                         state_q == DISCARD);

  assign accept = io.snk_valid && io.snk_ready;

  assign cmp_a = buf_q[idx_q];
  assign cmp_b = buf_q[idx_q + IW'(1)];

  sort_cmp_swap #(
    .DATA_WIDTH (DATA_WIDTH),
    .ASCENDING  (ASCENDING)
  ) u_cmp (
    .a     (cmp_a),
    .b     (cmp_b),
    .out_a (cmp_oa),
    .out_b (cmp_ob),
    .swap  (cmp_sw)
  );

  // Last index of this pass is len-2-p.
  assign lim        = len_q - LW'(2) - pass_q;
  assign last_cmp   = ({1'b0, idx_q} == lim);
  assign final_pass = (pass_q == len_q - LW'(2));
  assign sorted     = last_cmp &&
                      (!(swp_q || cmp_sw) || final_pass);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pass_d  = pass_q;
    idx_d   = idx_q;
    swp_d   = swp_q;
    oidx_d  = oidx_q;
    vld_d   = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    dat_d   = dat_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = cnt_q[IW-1:0];
    sw_en   = 1'b0;

    // Sort counters start from zero on entry.
    if (state_q != SORT) begin
      pass_d = '0;
      idx_d  = '0;
      swp_d  = 1'b0;
    end

    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (io.snk_sop) begin
            wr_en  = 1'b1;
            wr_idx = '0;
            cnt_d  = LW'(1);
            if (io.snk_eop) begin
              len_d   = LW'(1);
              state_d = OUTPUT;
              vld_d   = 1'b1;
              sop_d   = 1'b1;
              eop_d   = 1'b1;
              dat_d   = io.snk_data;
            end else begin
              state_d = LOAD;
            end
          end else if (state_q == LOAD) begin
            wr_en = 1'b1;
            if (io.snk_eop) begin
              len_d   = cnt_q + LW'(1);
              state_d = SORT;
            end else if (cnt_q == LW'(MAX_LENGTH - 1)) begin
              len_d   = LW'(MAX_LENGTH);
              err_d   = 1'b1;
              state_d = DISCARD;
            end else begin
              cnt_d = cnt_q + LW'(1);
            end
          end
        end
      end
      DISCARD: begin
        if (accept && io.snk_eop) begin
          state_d = SORT;
        end
      end
      SORT: begin
        sw_en = cmp_sw;
        if (last_cmp) begin
          if (sorted) begin
            state_d = OUTPUT;
            oidx_d  = LW'(1);
            vld_d   = 1'b1;
            sop_d   = 1'b1;
            // Final compare may rewrite buf[0].
            dat_d   = (idx_q == '0) ? cmp_oa : buf_q[0];
          end else begin
            pass_d = pass_q + LW'(1);
            idx_d  = '0;
            swp_d  = 1'b0;
          end
        end else begin
          idx_d = idx_q + IW'(1);
          swp_d = swp_q | cmp_sw;
        end
      end
      OUTPUT: begin
        if (eop_q) begin
          state_d = IDLE;
        end else begin
          vld_d  = 1'b1;
          dat_d  = buf_q[oidx_q[IW-1:0]];
          eop_d  = (oidx_q == len_q - LW'(1));
          oidx_d = oidx_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge snk_clock) begin
    if (snk_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      pass_q  <= '0;
      oidx_q  <= '0;
      idx_q   <= '0;
      swp_q   <= 1'b0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      dat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pass_q  <= pass_d;
      oidx_q  <= oidx_d;
      idx_q   <= idx_d;
      swp_q   <= swp_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge snk_clock) begin
    if (wr_en) begin
      buf_q[wr_idx] <= io.snk_data;
    end
    if (sw_en) begin
      buf_q[idx_q]          <= cmp_oa;
      buf_q[idx_q + IW'(1)] <= cmp_ob;
    end
  end

  assign io.src_valid = vld_q;
  assign io.src_sop   = sop_q;
  assign io.src_eop   = eop_q;
  assign io.src_data  = dat_q;

  assign busy         = (state_q == SORT) ||
                        (state_q == OUTPUT);
  assign pkt_len      = len_q;
  assign err_overflow = err_q;

endmodule
